bfly_sched: RTL

BFLY_SCHED -- requirements
Module: bfly_sched

---
 rtl/bfly_pkg.sv | 21 ++
 rtl/bfly_addr_fifo.sv | 64 ++++++
 rtl/bfly_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bfly_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bfly_pkg
// Description : Butterfly mode encodings and scheduler FSM state encodings,
//               shared by the scheduler and the butterfly datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package bfly_pkg;

    localparam logic [1:0] MODE_FFT  = 2'b00;
    localparam logic [1:0] MODE_IFFT = 2'b01;
    localparam logic [1:0] MODE_NTT  = 2'b10;
    localparam logic [1:0] MODE_INTT = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/bfly_addr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bfly_addr_fifo
// Description : Synchronous FIFO with occupancy count, holding write-back
//               address pairs for butterflies in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module bfly_addr_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (c_AW+1)'(DEPTH));
    assign w_push = push && !full;
    assign w_pop  = pop && (r_count != '0);
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bfly_sched.sv
`default_nettype none
// ============================================================================
// Module      : bfly_sched
// Description : In-place radix-2 butterfly scheduler: walks the stages of an
//               N-point transform, feeds pairs to a butterfly and writes back.
// Revision    : 1.0 - initial release
// ============================================================================
module bfly_sched
    import bfly_pkg::*;
#(
    parameter int pDATA_WIDTH = 128,
    parameter int pLOG_N      = 10,
    parameter int pAF_DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [pLOG_N-1:0]      rd_addr_a,
    output logic [pLOG_N-1:0]      rd_addr_b,
    input  logic [pDATA_WIDTH-1:0] rd_data_a,
    input  logic [pDATA_WIDTH-1:0] rd_data_b,
    output logic [pLOG_N-2:0]      tw_addr,
    input  logic [pDATA_WIDTH-1:0] tw_data,
    output logic [1:0]             bf_mode,
    output logic                   bf_i_vld,
    output logic [pDATA_WIDTH-1:0] bf_ai,
    output logic [pDATA_WIDTH-1:0] bf_bi,
    output logic [pDATA_WIDTH-1:0] bf_gm,
    input  logic                   bf_i_rdy,
    input  logic                   bf_o_vld,
    input  logic [pDATA_WIDTH-1:0] bf_ao,
    input  logic [pDATA_WIDTH-1:0] bf_bo,
    output logic                   bf_o_rdy,
    output logic                   wr_en,
    output logic [pLOG_N-1:0]      wr_addr_a,
    output logic [pLOG_N-1:0]      wr_addr_b,
    output logic [pDATA_WIDTH-1:0] wr_data_a,
    output logic [pDATA_WIDTH-1:0] wr_data_b
);

    localparam int                c_SW    = $clog2(pLOG_N);
    localparam int                c_CW    = $clog2(pAF_DEPTH) + 1;
    localparam logic [pLOG_N-1:0] c_ONE_L = {{(pLOG_N-1){1'b0}}, 1'b1};
    localparam logic [pLOG_N-2:0] c_ONE_J = {{(pLOG_N-2){1'b0}}, 1'b1};
    localparam logic [pLOG_N-2:0] c_ONES  = {(pLOG_N-1){1'b1}};
    localparam logic [c_SW-1:0]   c_LAST  = c_SW'(pLOG_N - 1);

    logic [1:0]             r_state;
    logic [c_SW-1:0]        r_stage;
    logic [pLOG_N-2:0]      r_j;
    logic [1:0]             r_mode;
    logic                   r_inflight;
    logic [1:0]             r_buf_cnt;
    logic                   r_buf_wp;
    logic                   r_buf_rp;
    logic [pDATA_WIDTH-1:0] r_buf_a [2];
    logic [pDATA_WIDTH-1:0] r_buf_b [2];
    logic [pDATA_WIDTH-1:0] r_buf_g [2];

    logic [c_SW-1:0]        w_rshift;
    logic [pLOG_N-2:0]      w_mask;
    logic [pLOG_N-2:0]      w_k;
    logic [pLOG_N-2:0]      w_hi;
    logic [pLOG_N-1:0]      w_span;
    logic [pLOG_N-1:0]      w_addr_a;
    logic [pLOG_N-1:0]      w_addr_b;
    logic [pLOG_N-2:0]      w_tw;
    logic                   w_issue;
    logic                   w_buf_empty;
    logic                   w_vld;
    logic                   w_buf_push;
    logic                   w_buf_pop;
    logic [2*pLOG_N-1:0]    w_head;
    logic [c_CW-1:0]        w_fifo_cnt;
    logic                   w_fifo_full;
    logic                   w_fifo_busy;

    // j splits into a group part (upper bits) and an offset k inside the
    // group; a zero bit inserted at the span position gives the A address.
    always_comb begin
        w_rshift = c_LAST - r_stage;
        w_mask   = ~(c_ONES << w_rshift);
        w_k      = r_j & w_mask;
        w_hi     = r_j & ~w_mask;
        w_span   = c_ONE_L << w_rshift;
        w_addr_a = {w_hi, 1'b0} | {1'b0, w_k};
        w_addr_b = w_addr_a | w_span;
        w_tw     = w_k << r_stage;
    end

    assign w_issue = !rst && (r_state == ST_RUN) && !w_fifo_full
                     && (({1'b0, r_buf_cnt} + {2'b00, r_inflight}) < 3'd2);

    // Returning read data bypasses the empty buffer so it is presented the
    // cycle after the read; it is captured only if not consumed at once.
    assign w_buf_empty = (r_buf_cnt == 2'd0);
    assign w_vld       = !rst && (!w_buf_empty || r_inflight);
    assign w_buf_pop   = w_vld && bf_i_rdy && !w_buf_empty;
    assign w_buf_push  = r_inflight && !(w_buf_empty && bf_i_rdy);

    assign w_fifo_busy = (w_fifo_cnt != '0);

    assign busy      = !rst && (r_state != ST_IDLE);
    assign done      = !rst && (r_state == ST_DONE);
    assign rd_en     = w_issue;
    assign rd_addr_a = w_issue ? w_addr_a : '0;
    assign rd_addr_b = w_issue ? w_addr_b : '0;
    assign tw_addr   = w_issue ? w_tw : '0;
    assign bf_mode   = rst ? MODE_FFT : r_mode;
    assign bf_i_vld  = w_vld;
    assign bf_ai     = w_buf_empty ? rd_data_a : r_buf_a[r_buf_rp];
    assign bf_bi     = w_buf_empty ? rd_data_b : r_buf_b[r_buf_rp];
    assign bf_gm     = w_buf_empty ? tw_data   : r_buf_g[r_buf_rp];
    assign bf_o_rdy  = !rst && w_fifo_busy;
    assign wr_en     = bf_o_rdy && bf_o_vld;
    assign wr_addr_a = wr_en ? w_head[2*pLOG_N-1:pLOG_N] : '0;
    assign wr_addr_b = wr_en ? w_head[pLOG_N-1:0] : '0;
    assign wr_data_a = bf_ao;
    assign wr_data_b = bf_bo;

    bfly_addr_fifo #(
        .WIDTH (2*pLOG_N),
        .DEPTH (pAF_DEPTH)
    ) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_issue),
        .push_data ({w_addr_a, w_addr_b}),
        .pop       (wr_en),
        .head      (w_head),
        .count     (w_fifo_cnt),
        .full      (w_fifo_full)
    );

    always_ff @(posedge clk) begin
        if (w_buf_push) begin
            r_buf_a[r_buf_wp] <= rd_data_a;
            r_buf_b[r_buf_wp] <= rd_data_b;
            r_buf_g[r_buf_wp] <= tw_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_stage    <= '0;
            r_j        <= '0;
            r_mode     <= MODE_FFT;
            r_inflight <= 1'b0;
            r_buf_cnt  <= 2'd0;
            r_buf_wp   <= 1'b0;
            r_buf_rp   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_buf_push) begin
                r_buf_wp <= ~r_buf_wp;
            end
            if (w_buf_pop) begin
                r_buf_rp <= ~r_buf_rp;
            end
            case ({w_buf_push, w_buf_pop})
                2'b10:   r_buf_cnt <= r_buf_cnt + 2'd1;
                2'b01:   r_buf_cnt <= r_buf_cnt - 2'd1;
                default: r_buf_cnt <= r_buf_cnt;
            endcase

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_stage <= '0;
                        r_j     <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_issue) begin
                        if (&r_j) begin
                            r_j     <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_j <= r_j + c_ONE_J;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Stage barrier: every pair of this stage must be written.
                    if (!w_fifo_busy) begin
                        if (r_stage == c_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_stage <= r_stage + c_SW'(1);
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
